reg_read_port: RTL and testbench
================================

# reg_read_port

Registered read side of the 16 x 32-bit CPU register bank. Takes the bank's sixteen register outputs and serves two-operand reads (Rn/Rm) to the datapath over a valid/ready handshake. Also provides a debug dump mode that streams r0..r15 in order on the same handshake. Sits between the register bank outputs and the execute stage and debug readout.

## Interface
- DATA_W, 32, register width; all data ports use this width.
- NUM_REGS, 16, register count; fixed at 16, index width 4.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; no asynchronous paths.
- r0 .. r15  in  DATA_W each  current register bank contents.
- rd_req  in  1  level; request a two-operand read.
- rd_addr_a  in  4  operand A register index.
- rd_addr_b  in  4  operand B register index.
- dump_start  in  1  request a sequential dump of r0..r15.
- rd_ready  in  1  consumer accepts the current output beat.
- rd_valid  out  1  rd_data_a/rd_data_b/rd_idx hold a valid beat.
- rd_data_a  out  DATA_W  operand A, or dump data.
- rd_data_b  out  DATA_W  operand B; 0 during dump.
- rd_idx  out  4  index of rd_data_a (rd_addr_a on reads, dump counter on dumps).
- busy  out  1  state != IDLE.
- dump_done  out  1  one-cycle pulse after the r15 dump beat is accepted.

## Operation
- States: IDLE, HOLD (single read beat outstanding), DUMP (streaming).
- IDLE, dump_start=1: go DUMP; capture r0 into rd_data_a, rd_data_b=0, rd_idx=0, rd_valid=1. dump_start wins over simultaneous rd_req; rd_req stays pending.
- IDLE, rd_req=1 (no dump_start): capture r[rd_addr_a], r[rd_addr_b], rd_idx=rd_addr_a, rd_valid=1, go HOLD.
- IDLE, neither: outputs hold; rd_valid=0.
- HOLD, rd_ready=0: all outputs frozen; rd_req/addresses/dump_start ignored.
- HOLD, rd_ready=1, rd_req=1: back-to-back; capture new operands same edge, rd_valid stays 1, stay HOLD.
- HOLD, rd_ready=1, rd_req=0: rd_valid=0, go IDLE. dump_start is only honoured from IDLE.
- DUMP, rd_ready=1, rd_idx<15: rd_idx+1, capture r[rd_idx+1] at that edge.
- DUMP, rd_ready=1, rd_idx=15: rd_valid=0, dump_done=1 next cycle, go IDLE. No wrap to 0.
- DUMP ignores rd_req and dump_start. Data is snapshotted when the beat is loaded; later bank changes do not alter a presented beat.
- rd_addr_a == rd_addr_b is legal; both outputs carry the same register.

## Timing
- Reset values: state IDLE, rd_valid 0, rd_data_a 0, rd_data_b 0, rd_idx 0, busy 0, dump_done 0.
- Reset mid-HOLD or mid-DUMP aborts next edge to reset values; no dump_done.
- Read latency: rd_req sampled high in IDLE at edge N -> rd_valid high after edge N.
- Throughput: one beat per cycle while rd_ready=1 (and rd_req=1 for reads).
- Full dump with rd_ready tied high: 16 valid cycles, then dump_done pulses in the cycle after the last beat.
- Outputs are registered; no combinational path from any input to any output.

## Structure
- Package reg_read_pkg: DATA_W, NUM_REGS, IDX_W=4, state enum {IDLE, HOLD, DUMP}.
- Sub-module reg_mux16: combinational 16:1 DATA_W mux (sel[3:0], r0..r15 -> q). Instantiate twice. Instance A select = rd_idx+1 in DUMP, 0 on dump entry, rd_addr_a otherwise. Instance B select = rd_addr_b.
- Top holds the FSM, dump counter (rd_idx), and output registers.

## Test plan
- Reset: r_n = 0x1000_0000+n; assert reset mid-dump at rd_idx=7 -> next cycle all outputs 0, state IDLE, no dump_done.
- Single read: rd_req=1, a=3, b=12, rd_ready=1 -> one cycle later rd_valid=1, rd_data_a=0x1000_0003, rd_data_b=0x1000_000C, rd_idx=3.
- Backpressure: rd_ready=0 for 4 cycles; change r3 to 0xDEAD_BEEF and the addresses -> outputs unchanged until rd_ready=1.
- Back-to-back: rd_req held, addresses (1,2),(5,5),(15,0), rd_ready=1 -> three consecutive beats, 5/5 gives both 0x1000_0005, rd_valid never drops.
- Dump: dump_start with rd_req in IDLE, rd_ready toggled 1/0 -> indices 0..15 in order with values 0x1000_0000..0x1000_000F, rd_data_b=0, dump_done a single pulse after beat 15. The pending read is served afterward.
- Ignore: dump_start during HOLD and rd_req during DUMP -> no effect on the current transfer.

Source files
------------

// File: rtl/reg_read_pkg.sv
// Shared parameters and FSM state encoding for the register-bank read port.
package reg_read_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DUMP = 2'd2
  } state_t;

endpackage

// File: rtl/reg_mux16.sv
// Combinational 16:1 selector over the register bank outputs.
module reg_mux16
  import reg_read_pkg::*;
(
  input  logic [IDX_W-1:0]  sel,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  input  logic [DATA_W-1:0] r5,
  input  logic [DATA_W-1:0] r6,
  input  logic [DATA_W-1:0] r7,
  input  logic [DATA_W-1:0] r8,
  input  logic [DATA_W-1:0] r9,
  input  logic [DATA_W-1:0] r10,
  input  logic [DATA_W-1:0] r11,
  input  logic [DATA_W-1:0] r12,
  input  logic [DATA_W-1:0] r13,
  input  logic [DATA_W-1:0] r14,
  input  logic [DATA_W-1:0] r15,
  output logic [DATA_W-1:0] q
);

  always_comb begin
    q = '0;
    case (sel)
      4'd0:    q = r0;
      4'd1:    q = r1;
      4'd2:    q = r2;
      4'd3:    q = r3;
      4'd4:    q = r4;
      4'd5:    q = r5;
      4'd6:    q = r6;
      4'd7:    q = r7;
      4'd8:    q = r8;
      4'd9:    q = r9;
      4'd10:   q = r10;
      4'd11:   q = r11;
      4'd12:   q = r12;
      4'd13:   q = r13;
      4'd14:   q = r14;
      4'd15:   q = r15;
      default: q = '0;
    endcase
  end

endmodule

// File: rtl/reg_read_port.sv
// Registered two-operand read port with a sequential r0..r15 dump mode.
// Handshake: a beat moves only on a clock edge where rd_valid && rd_ready; while rd_valid && !rd_ready every output holds.
module reg_read_port
  import reg_read_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] r0,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [DATA_W-1:0] r3,
  input  logic [DATA_W-1:0] r4,
  input  logic [DATA_W-1:0] r5,
  input  logic [DATA_W-1:0] r6,
  input  logic [DATA_W-1:0] r7,
  input  logic [DATA_W-1:0] r8,
  input  logic [DATA_W-1:0] r9,
  input  logic [DATA_W-1:0] r10,
  input  logic [DATA_W-1:0] r11,
  input  logic [DATA_W-1:0] r12,
  input  logic [DATA_W-1:0] r13,
  input  logic [DATA_W-1:0] r14,
  input  logic [DATA_W-1:0] r15,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_addr_a,
  input  logic [IDX_W-1:0]  rd_addr_b,
  input  logic              dump_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              busy,
  output logic              dump_done
);

  state_t            state, state_d;
  logic              valid_d, done_d;
  logic [DATA_W-1:0] a_d, b_d, mux_a, mux_b;
  logic [IDX_W-1:0]  idx_d, sel_a;

  reg_mux16 u_mux_a (
    .sel(sel_a), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .q(mux_a)
  );

  reg_mux16 u_mux_b (
    .sel(rd_addr_b), .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
    .q(mux_b)
  );

  always_comb begin
    state_d = state;
    valid_d = rd_valid;
    a_d     = rd_data_a;
    b_d     = rd_data_b;
    idx_d   = rd_idx;
    done_d  = 1'b0;
    sel_a   = rd_addr_a;
    case (state)
      IDLE: begin
        // A dump wins over a simultaneous read; the read stays pending on rd_req.
        if (dump_start) begin
          sel_a   = '0;
          state_d = DUMP;
          valid_d = 1'b1;
          a_d     = mux_a;
          b_d     = '0;
          idx_d   = '0;
        end else if (rd_req) begin
          state_d = HOLD;
          valid_d = 1'b1;
          a_d     = mux_a;
          b_d     = mux_b;
          idx_d   = rd_addr_a;
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (rd_ready) begin
          if (rd_req) begin
            a_d   = mux_a;
            b_d   = mux_b;
            idx_d = rd_addr_a;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      DUMP: begin
        sel_a = rd_idx + 4'd1;
        if (rd_ready) begin
          if (rd_idx == 4'd15) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = rd_idx + 4'd1;
            a_d   = mux_a;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_valid  <= 1'b0;
      rd_data_a <= '0;
      rd_data_b <= '0;
      rd_idx    <= '0;
      busy      <= 1'b0;
      dump_done <= 1'b0;
    end else begin
      state     <= state_d;
      rd_valid  <= valid_d;
      rd_data_a <= a_d;
      rd_data_b <= b_d;
      rd_idx    <= idx_d;
      busy      <= (state_d != IDLE);
      dump_done <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_read_port.sv
// Directed bench for reg_read_port: reads, backpressure, back-to-back, dump, reset abort.
module tb_reg_read_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] r [16];
  logic        rd_req, dump_start, rd_ready;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic        rd_valid, busy, dump_done;
  logic [31:0] rd_data_a, rd_data_b;
  logic [3:0]  rd_idx;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  reg_read_port dut (
    .clk(clk), .reset(reset),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]), .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .r8(r[8]), .r9(r[9]), .r10(r[10]), .r11(r[11]), .r12(r[12]), .r13(r[13]), .r14(r[14]), .r15(r[15]),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .dump_start(dump_start),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_idx(rd_idx), .busy(busy), .dump_done(dump_done)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++;
    if ({rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done} !== 71'd0) begin
      bad++;
      $display("FAIL reset_state got v=%0b idx=%0d a=%h b=%h busy=%0b done=%0b exp all zero",
               rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done);
    end
    reset = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got v=%0b busy=%0b exp 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd12; rd_ready = 1'b1;
    tick();
    total++;
    if ({rd_valid, rd_idx, rd_data_a, rd_data_b, busy} !== {1'b1, 4'd3, 32'h1000_0003, 32'h1000_000C, 1'b1}) begin
      bad++;
      $display("FAIL single_read got v=%0b idx=%0d a=%h b=%h busy=%0b exp v=1 idx=3 a=10000003 b=1000000c busy=1",
               rd_valid, rd_idx, rd_data_a, rd_data_b, busy);
    end
    rd_req = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_read_release got v=%0b busy=%0b exp 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    rd_req = 1'b1; rd_addr_a = 4'd3; rd_addr_b = 4'd12; rd_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      r[3] = 32'hDEAD_BEEF;
      rd_addr_a = 4'(i + 6);
      rd_addr_b = 4'(i + 1);
      dump_start = 1'b1;
      tick();
      total++;
      if ({rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done} !==
          {1'b1, 4'd3, 32'h1000_0003, 32'h1000_000C, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL backpressure_hold[%0d] got v=%0b idx=%0d a=%h b=%h exp v=1 idx=3 a=10000003 b=1000000c",
                 i, rd_valid, rd_idx, rd_data_a, rd_data_b);
      end
    end
    rd_ready = 1'b1; rd_req = 1'b0; dump_start = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_release got v=%0b busy=%0b exp 0 0", rd_valid, busy);
    end
    r[3] = 32'h1000_0003;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  pa [3];
    logic [3:0]  pb [3];
    logic [31:0] ea [3];
    logic [31:0] eb [3];
    pa[0] = 4'd1;  pb[0] = 4'd2;  ea[0] = 32'h1000_0001; eb[0] = 32'h1000_0002;
    pa[1] = 4'd5;  pb[1] = 4'd5;  ea[1] = 32'h1000_0005; eb[1] = 32'h1000_0005;
    pa[2] = 4'd15; pb[2] = 4'd0;  ea[2] = 32'h1000_000F; eb[2] = 32'h1000_0000;
    rd_req = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr_a = pa[i]; rd_addr_b = pb[i];
      tick();
      total++;
      if ({rd_valid, rd_idx, rd_data_a, rd_data_b} !== {1'b1, pa[i], ea[i], eb[i]}) begin
        bad++;
        $display("FAIL back_to_back[%0d] got v=%0b idx=%0d a=%h b=%h exp v=1 idx=%0d a=%h b=%h",
                 i, rd_valid, rd_idx, rd_data_a, rd_data_b, pa[i], ea[i], eb[i]);
      end
    end
    rd_req = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_end got v=%0b exp 0", rd_valid);
    end
  endtask

  task automatic test_dump();
    int cyc;
    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
    dump_start = 1'b1; rd_req = 1'b1; rd_addr_a = 4'd7; rd_addr_b = 4'd9; rd_ready = 1'b0;
    tick();
    dump_start = 1'b0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 80) begin
      rd_ready = (cyc % 2 == 0);
      total++;
      if ({rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done} !==
          {1'b1, exp_q[0], 32'h1000_0000 + 32'(exp_q[0]), 32'd0, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL dump_beat cyc=%0d got v=%0b idx=%0d a=%h b=%h done=%0b exp v=1 idx=%0d a=%h b=0 done=0",
                 cyc, rd_valid, rd_idx, rd_data_a, rd_data_b, dump_done, exp_q[0], 32'h1000_0000 + 32'(exp_q[0]));
      end
      if (rd_ready) void'(exp_q.pop_front());
      tick();
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL dump_timeout got remaining=%0d exp 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if ({rd_valid, dump_done} !== 2'b01) begin
      bad++;
      $display("FAIL dump_done_pulse got v=%0b done=%0b exp v=0 done=1", rd_valid, dump_done);
    end
    rd_ready = 1'b1;
    tick();
    total++;
    if ({rd_valid, rd_idx, rd_data_a, rd_data_b, dump_done} !== {1'b1, 4'd7, 32'h1000_0007, 32'h1000_0009, 1'b0}) begin
      bad++;
      $display("FAIL pending_read got v=%0b idx=%0d a=%h b=%h done=%0b exp v=1 idx=7 a=10000007 b=10000009 done=0",
               rd_valid, rd_idx, rd_data_a, rd_data_b, dump_done);
    end
    rd_req = 1'b0;
    tick();
    total++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL pending_read_end got v=%0b busy=%0b exp 0 0", rd_valid, busy);
    end
  endtask

  task automatic test_reset_mid_dump();
    dump_start = 1'b1; rd_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if ({rd_valid, rd_idx, rd_data_a} !== {1'b1, 4'd7, 32'h1000_0007}) begin
      bad++;
      $display("FAIL dump_mid got v=%0b idx=%0d a=%h exp v=1 idx=7 a=10000007", rd_valid, rd_idx, rd_data_a);
    end
    reset = 1'b1;
    tick();
    total++;
    if ({rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done} !== 71'd0) begin
      bad++;
      $display("FAIL reset_mid_dump got v=%0b idx=%0d a=%h b=%h busy=%0b done=%0b exp all zero",
               rd_valid, rd_idx, rd_data_a, rd_data_b, busy, dump_done);
    end
    reset = 1'b0;
    tick();
    total++;
    if ({rd_valid, busy, dump_done} !== 3'b000) begin
      bad++;
      $display("FAIL after_abort got v=%0b busy=%0b done=%0b exp 0 0 0", rd_valid, busy, dump_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) r[i] = 32'h1000_0000 + 32'(i);
    reset = 1'b1; rd_req = 1'b0; dump_start = 1'b0; rd_ready = 1'b0;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0;
    test_reset();
    test_single_read();
    test_backpressure();
    test_back_to_back();
    test_dump();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
